icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetch stage (upstream requester) and the byte-wide memory controller.
- Serves one word-aligned 32-bit instruction per request.
  - Hits answer with 1-cycle latency.
  - Misses fill one word, one byte at a time, then answer.
- Produces the `Inst`/`Read_ready` pair that the fetch stage consumes; samples the fetch stage's `addr`/`rn`.

Parameters:
- ADDR_BITS, 18, physical address bits used; upper bits of `addr` are ignored.
- INDEX_BITS, 6, log2 of line count; one 32-bit word per line.
- Derived: TAG_BITS = ADDR_BITS - 2 - INDEX_BITS (default 10).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; freezes block when low
- addr  in  32  fetch address; bits [1:0] ignored
- rn  in  1  read request, level-sensitive
- Inst  out  32  instruction word
- Read_ready  out  1  one-cycle pulse: Inst valid
- mem_req  out  1  memory read request, held for the whole fill
- mem_addr  out  32  byte address currently requested
- mem_valid  in  1  mem_data valid this cycle
- mem_data  in  8  returned byte

Behaviour:
- Reset (rst=1 at posedge):
  - All valid bits cleared; state goes to IDLE; byte counter = 0.
  - Outputs: Read_ready=0, mem_req=0, mem_addr=0, Inst=0.
  - Reset mid-fill aborts the fill; the partial word is discarded; later mem_valid pulses are ignored until a new fill starts.
- rdy=0: no register changes at all, including memory bytes and valid bits. Outputs hold their values.
- Address split: idx = addr[INDEX_BITS+1:2]; tag = addr[ADDR_BITS-1:INDEX_BITS+2].
- State IDLE: sample rn/addr at each posedge.
  - rn=1, hit (valid[idx] and tag match): Inst <= data[idx], Read_ready <= 1, go to RESP. Total latency 1 cycle.
  - rn=1, miss: latch line address {addr[ADDR_BITS-1:2],2'b00}; mem_req <= 1; mem_addr <= line base; counter <= 0; go to FILL.
  - rn=0: stay in IDLE.
- State FILL:
  - On each mem_valid=1: write mem_data into byte [counter] of the fill buffer (little-endian; byte 0 = bits 7:0), counter++, mem_addr <= line base + counter + 1.
  - When the 4th byte arrives (counter==3 and mem_valid):
    - mem_req <= 0.
    - Write tag, data and valid for idx.
    - Inst <= assembled word, Read_ready <= 1, go to RESP.
  - The fetch address and rn are not sampled in FILL.
- State RESP (exactly one cycle): Read_ready is high here.
  - rn is ignored this cycle, because the requester still shows its old addr.
  - Next: Read_ready <= 0, go to IDLE.
- Read_ready is never high for two consecutive cycles. Inst holds its value until the next response.
- A fill evicts the previous line at the same index unconditionally; there is no replacement choice.
- A mem_valid pulse outside FILL is ignored.
- No flush input. Redirects are handled by the requester, which simply discards the response.

Optional Feature:
- Macro ICACHE_STAT_EN.
- When defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Counters reset to 0 and increment at request acceptance in IDLE (hit or miss respectively).
  - Counters are frozen when rdy=0 and wrap at 2^32.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss, addr=0x0, memory bytes 13,00,00,00 each one cycle after request -> mem_addr steps 0x0..0x3. Then Read_ready pulses with Inst=0x00000013, 1 cycle after the 4th byte.
- Repeat addr=0x0 after RESP -> hit: Read_ready the cycle after rn is sampled, Inst=0x00000013, mem_req stays 0.
- Conflict: fill 0x0 (0x00000013), then 0x100 (0x00100093) -> second is a miss. Re-reading 0x0 misses again and refills.
- Aliasing: addr=0x40000 after 0x0 is cached -> hit, Inst=0x00000013 (upper bits ignored). addr=0x3 returns the same word as 0x0.
- rst asserted after 2 of 4 bytes -> mem_req=0 next cycle. A following request to 0x0 misses and refetches all 4 bytes.
- rdy=0 for 3 cycles mid-fill, mem_valid high during the stall -> stalled bytes not consumed. After rdy=1, the fill completes with the correct word.

Source files
------------

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with one 32-bit
// word per line. Hits answer one cycle after the request is sampled. Misses
// fetch the word one byte at a time from a byte-wide memory controller.
// Optional build macro: ICACHE_STAT_EN adds hit_cnt/miss_cnt statistics outputs.
module icache_direct #(
    parameter int ADDR_BITS  = 18,
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] addr,
    input  logic        rn,
    output logic [31:0] Inst,
    output logic        Read_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_BITS = ADDR_BITS - 2 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_reg;
    logic [LINES-1:0]      valid_reg;
    logic [1:0]            count_reg;
    logic [23:0]           fill_buf_reg;
    logic [INDEX_BITS-1:0] fill_idx_reg;
    logic [TAG_BITS-1:0]   fill_tag_reg;
    logic [31:0]           line_base_reg;
    logic [31:0]           inst_reg;
    logic                  read_ready_reg;
    logic                  mem_req_reg;
    logic [31:0]           mem_addr_reg;

    // Tag and data stores are read asynchronously so the hit decision and the
    // returned word are both available in the cycle the request is sampled.
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [31:0]           req_base;
    logic                  hit;
    logic [31:0]           fill_word;
    logic                  fill_done;
    logic                  addr_unused;

    assign req_idx     = addr[INDEX_BITS+1:2];
    assign req_tag     = addr[ADDR_BITS-1:INDEX_BITS+2];
    assign req_base    = {{(32-ADDR_BITS){1'b0}}, addr[ADDR_BITS-1:2], 2'b00};
    assign hit         = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill_word   = {mem_data, fill_buf_reg};
    assign fill_done   = (state_reg == FILL) && mem_valid && (count_reg == 2'd3);
    // Upper address bits and the byte offset do not take part in lookup.
    assign addr_unused = ^{addr[31:ADDR_BITS], addr[1:0]};

    assign Inst       = inst_reg;
    assign Read_ready = read_ready_reg;
    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;

    // Byte lanes of the fill buffer: each incoming byte lands in the lane
    // selected by the byte counter; the last byte bypasses the buffer.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fill_lane
            always_ff @(posedge clk) begin
                if (!rst && rdy && state_reg == FILL && mem_valid && count_reg == 2'(gi)) begin
                    fill_buf_reg[gi*8 +: 8] <= mem_data;
                end
            end
        end
    endgenerate

    // Line install: tag and data are written when the final byte of a fill arrives.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_done) begin
            tag_mem[fill_idx_reg]  <= fill_tag_reg;
            data_mem[fill_idx_reg] <= fill_word;
        end
    end

    // Control FSM: lookup in IDLE, byte-serial refill in FILL, one-cycle response in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            count_reg      <= 2'd0;
            fill_idx_reg   <= '0;
            fill_tag_reg   <= '0;
            line_base_reg  <= 32'd0;
            inst_reg       <= 32'd0;
            read_ready_reg <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= 32'd0;
        end else if (rdy) begin
            case (state_reg)
                IDLE: begin
                    if (rn) begin
                        if (hit) begin
                            inst_reg       <= data_mem[req_idx];
                            read_ready_reg <= 1'b1;
                            state_reg      <= RESP;
                        end else begin
                            line_base_reg <= req_base;
                            fill_idx_reg  <= req_idx;
                            fill_tag_reg  <= req_tag;
                            mem_req_reg   <= 1'b1;
                            mem_addr_reg  <= req_base;
                            count_reg     <= 2'd0;
                            state_reg     <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_valid) begin
                        count_reg    <= count_reg + 2'd1;
                        mem_addr_reg <= line_base_reg + {30'd0, count_reg} + 32'd1;
                        if (count_reg == 2'd3) begin
                            mem_req_reg             <= 1'b0;
                            valid_reg[fill_idx_reg] <= 1'b1;
                            inst_reg                <= fill_word;
                            read_ready_reg          <= 1'b1;
                            state_reg               <= RESP;
                        end
                    end
                end
                RESP: begin
                    // The requester still presents the old address here, so rn is ignored.
                    read_ready_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;

    // Statistics: count accepted requests in IDLE, split by lookup outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg  <= 32'd0;
            miss_cnt_reg <= 32'd0;
        end else if (rdy && state_reg == IDLE && rn) begin
            if (hit) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end else begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: cold miss, hit, conflict, aliasing,
// reset during fill, rdy stall during fill and back-to-back hits.
module tb_icache_direct;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] addr;
    logic        rn;
    logic [31:0] Inst;
    logic        Read_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_data;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks;
    int errors;
    int exp_hits;
    int exp_misses;

    icache_direct dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .addr       (addr),
        .rn         (rn),
        .Inst       (Inst),
        .Read_ready (Read_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One read transaction. Inputs are driven and outputs sampled on negedges.
    // For a miss, bytes of 'word' are returned back to back; when stall_at is
    // 0..3, rdy is dropped for 3 cycles before byte stall_at with mem_valid high.
    task automatic do_read(input logic [31:0] a, input bit miss,
                           input logic [31:0] word, input int stall_at);
        logic [31:0] line;
        line = {14'd0, a[17:2], 2'b00};
        @(negedge clk);
        addr = a;
        rn   = 1'b1;
        @(negedge clk);
        rn = 1'b0;
        if (miss) begin
            exp_misses++;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== line || Read_ready !== 1'b0) begin
                errors++;
                $display("FAIL miss_start a=%h got req=%b maddr=%h rr=%b want req=1 maddr=%h rr=0",
                         a, mem_req, mem_addr, Read_ready, line);
            end
            for (int b = 0; b < 4; b++) begin
                if (b == stall_at) begin
                    rdy       = 1'b0;
                    mem_valid = 1'b1;
                    mem_data  = word[b*8 +: 8];
                    for (int s = 0; s < 3; s++) begin
                        @(negedge clk);
                        checks++;
                        if (mem_addr !== line + 32'(b) || mem_req !== 1'b1 || Read_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_hold b=%0d got maddr=%h req=%b rr=%b want maddr=%h req=1 rr=0",
                                     b, mem_addr, mem_req, Read_ready, line + 32'(b));
                        end
                    end
                    rdy = 1'b1;
                end
                mem_valid = 1'b1;
                mem_data  = word[b*8 +: 8];
                @(negedge clk);
                if (b < 3) begin
                    checks++;
                    if (mem_addr !== line + 32'(b) + 32'd1 || Read_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL fill_step b=%0d got maddr=%h rr=%b want maddr=%h rr=0",
                                 b, mem_addr, Read_ready, line + 32'(b) + 32'd1);
                    end
                end
            end
            mem_valid = 1'b0;
        end else begin
            exp_hits++;
        end
        checks++;
        if (Read_ready !== 1'b1 || Inst !== word || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL response a=%h got rr=%b inst=%h req=%b want rr=1 inst=%h req=0",
                     a, Read_ready, Inst, mem_req, word);
        end
        @(negedge clk);
        checks++;
        if (Read_ready !== 1'b0 || Inst !== word) begin
            errors++;
            $display("FAIL pulse_end a=%h got rr=%b inst=%h want rr=0 inst=%h", a, Read_ready, Inst, word);
        end
        $display("read a=%h %s inst=%h", a, miss ? "miss" : "hit ", Inst);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rn = 1'b0; addr = 32'd0; mem_valid = 1'b0; mem_data = 8'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (Read_ready !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'd0 || Inst !== 32'd0) begin
            errors++;
            $display("FAIL reset got rr=%b req=%b maddr=%h inst=%h want all zero",
                     Read_ready, mem_req, mem_addr, Inst);
        end
        rst = 1'b0;
        exp_hits = 0; exp_misses = 0;
        $display("reset done");
    endtask

    task automatic test_cold_miss();
        do_read(32'h0, 1'b1, 32'h0000_0013, 4);
    endtask

    task automatic test_hit();
        do_read(32'h0, 1'b0, 32'h0000_0013, 4);
    endtask

    task automatic test_aliasing();
        do_read(32'h0004_0000, 1'b0, 32'h0000_0013, 4);
        do_read(32'h0000_0003, 1'b0, 32'h0000_0013, 4);
        do_read(32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4);
        do_read(32'h0000_0000, 1'b0, 32'h0000_0013, 4);
        do_read(32'h0000_0004, 1'b0, 32'hDEAD_BEEF, 4);
    endtask

    task automatic test_conflict();
        do_read(32'h0000_0100, 1'b1, 32'h0010_0093, 4);
        do_read(32'h0000_0100, 1'b0, 32'h0010_0093, 4);
        do_read(32'h0000_0000, 1'b1, 32'h0000_0013, 4);
        do_read(32'h0000_0100, 1'b1, 32'h0010_0093, 4);
    endtask

    task automatic test_stall();
        do_read(32'h0000_0208, 1'b1, 32'h1234_5678, 2);
        do_read(32'h0000_0208, 1'b0, 32'h1234_5678, 4);
        do_read(32'h0000_0304, 1'b1, 32'hA5C3_0F81, 0);
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        addr = 32'h0; rn = 1'b1;
        @(negedge clk);
        rn = 1'b0;
        mem_valid = 1'b1; mem_data = 8'hAA;
        @(negedge clk);
        mem_data = 8'hBB;
        @(negedge clk);
        rst = 1'b1; mem_data = 8'hCC;
        @(negedge clk);
        rst = 1'b0; mem_data = 8'hDD;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0 || Read_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got req=%b maddr=%h rr=%b want req=0 maddr=0 rr=0",
                     mem_req, mem_addr, Read_ready);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0 || Read_ready !== 1'b0) begin
            errors++;
            $display("FAIL stray_valid got req=%b maddr=%h rr=%b want req=0 maddr=0 rr=0",
                     mem_req, mem_addr, Read_ready);
        end
        exp_hits = 0; exp_misses = 0;
        $display("reset during fill");
        do_read(32'h0000_0000, 1'b1, 32'h0000_0013, 4);
        do_read(32'h0000_0208, 1'b1, 32'h1234_5678, 4);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        addr = 32'h0; rn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) rn = 1'b0;
            checks++;
            if (Read_ready !== ((c % 2) == 0) || Inst !== 32'h0000_0013) begin
                errors++;
                $display("FAIL back_to_back c=%0d got rr=%b inst=%h want rr=%b inst=00000013",
                         c, Read_ready, Inst, (c % 2) == 0);
            end
        end
        exp_hits += 2;
        $display("back-to-back rn held: rr pattern checked");
    endtask

`ifdef ICACHE_STAT_EN
    task automatic test_stats();
        checks++;
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL stats got hit=%0d miss=%0d want hit=%0d miss=%0d",
                     hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
        $display("stats hit=%0d miss=%0d", hit_cnt, miss_cnt);
    endtask
`endif

    initial begin
        checks = 0; errors = 0; exp_hits = 0; exp_misses = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_aliasing();
        test_conflict();
        test_stall();
        test_reset_mid_fill();
        test_back_to_back();
`ifdef ICACHE_STAT_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
